external_bus_ctrl: RTL

- Parametrised external bus controller between the CPU-side MAR/MBR datapath and the external instruction ROM and data RAM.
- Replaces the single-cycle, control-signal-driven bus with a valid/ready request port and a registered single-beat response.
- Adds independent, configurable wait states for ROM and RAM, error reporting for illegal ROM writes, and back-to-back transfers.
- All memory-side strobes, address and write data are registered and held stable for the whole access window.

---
 rtl/external_bus_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/external_bus_ctrl.sv
// External bus controller: valid/ready CPU request port in front of the instruction
// ROM and data RAM, with per-space wait states and a registered single-beat response.
module external_bus_ctrl #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 8,
    parameter int ROM_WAIT = 0,
    parameter int RAM_WAIT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    input  logic              i_req_write,
    input  logic              i_req_rom,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_req_ready,
    output logic              o_rsp_valid,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic              o_rsp_err,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_rom_rd,
    output logic              o_ram_rd,
    output logic              o_ram_wr,
    input  logic [DATA_W-1:0] i_rom_data,
    input  logic [DATA_W-1:0] i_ram_data
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [3:0] ROM_W4 = 4'(ROM_WAIT);
    localparam logic [3:0] RAM_W4 = 4'(RAM_WAIT);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              wr_q, wr_d, rom_q, rom_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d, rsp_data_d;
    logic              rom_rd_d, ram_rd_d, ram_wr_d, rsp_valid_d, rsp_err_d;
    logic              accept;

    assign o_req_ready = i_rst_n & (state_q == IDLE || state_q == RESP);
    assign accept      = i_req_valid & o_req_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        rom_d       = rom_q;
        addr_d      = o_mem_addr;
        wdata_d     = o_mem_wdata;
        rom_rd_d    = o_rom_rd;
        ram_rd_d    = o_ram_rd;
        ram_wr_d    = o_ram_wr;
        rsp_valid_d = 1'b0;
        rsp_data_d  = o_rsp_data;
        rsp_err_d   = o_rsp_err;
        case (state_q)
            IDLE, RESP: begin
                state_d    = IDLE;
                rsp_data_d = '0;
                rsp_err_d  = 1'b0;
                addr_d     = '0;
                wdata_d    = '0;
                rom_rd_d   = 1'b0;
                ram_rd_d   = 1'b0;
                ram_wr_d   = 1'b0;
                if (accept) begin
                    wr_d  = i_req_write;
                    rom_d = i_req_rom;
                    // ROM is read-only: answer with an error without touching the bus
                    if (i_req_write && i_req_rom) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d  = ACCESS;
                        cnt_d    = i_req_rom ? ROM_W4 : RAM_W4;
                        addr_d   = i_req_addr;
                        wdata_d  = (i_req_write && !i_req_rom) ? i_req_wdata : '0;
                        rom_rd_d = i_req_rom;
                        ram_rd_d = !i_req_rom && !i_req_write;
                        ram_wr_d = !i_req_rom && i_req_write;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // final access cycle: memory data is sampled while the strobe is still up
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_data_d  = wr_q ? '0 : (rom_q ? i_rom_data : i_ram_data);
                    addr_d      = '0;
                    wdata_d     = '0;
                    rom_rd_d    = 1'b0;
                    ram_rd_d    = 1'b0;
                    ram_wr_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            wr_q        <= 1'b0;
            rom_q       <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_rom_rd    <= 1'b0;
            o_ram_rd    <= 1'b0;
            o_ram_wr    <= 1'b0;
            o_rsp_valid <= 1'b0;
            o_rsp_data  <= '0;
            o_rsp_err   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            rom_q       <= rom_d;
            o_mem_addr  <= addr_d;
            o_mem_wdata <= wdata_d;
            o_rom_rd    <= rom_rd_d;
            o_ram_rd    <= ram_rd_d;
            o_ram_wr    <= ram_wr_d;
            o_rsp_valid <= rsp_valid_d;
            o_rsp_data  <= rsp_data_d;
            o_rsp_err   <= rsp_err_d;
        end
    end

endmodule
